tc_rr_arbiter8: RTL

Eight-way round-robin arbiter that produces the 3-bit select index and disable flag for the downstream 3-to-8 one-hot decoder. It samples eight request lines, grants one requester at a time, holds the grant until the requester releases, drops its request, or exceeds a hold limit, then rotates priority. The registered outputs drive the decoder's `sel0`/`sel1`/`sel2`/`dis` inputs directly, so exactly one decoder output is high only while a grant is active.

---
 rtl/tc_rr_arbiter8.sv | 100 ++++++++++
 1 files changed

// File: rtl/tc_rr_arbiter8.sv
// rtl/tc_rr_arbiter8.sv - eight-way round-robin arbiter driving a 3-to-8 decoder select/disable
module tc_rr_arbiter8 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       rel,
    output logic       sel0,
    output logic       sel1,
    output logic       sel2,
    output logic       dis,
    output logic       grant_new
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

    state_t     state, state_nxt;
    logic [2:0] ptr, ptr_nxt;
    logic [2:0] gidx, gidx_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       dis_nxt, gn_nxt;
    logic [2:0] pick, scan;
    logic       found, term;

    // First requester at or after ptr, wrapping 7 -> 0.
    always_comb begin
        found = 1'b0;
        pick  = ptr;
        scan  = ptr;
        for (int i = 0; i < 8; i++) begin
            scan = ptr + 3'(i);
            if (!found && req[scan]) begin
                found = 1'b1;
                pick  = scan;
            end
        end
    end

    assign term = rel || !req[gidx] || ((HOLD_LIM != 8'd0) && (cnt == HOLD_LIM));

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        gidx_nxt  = gidx;
        cnt_nxt   = cnt;
        dis_nxt   = dis;
        gn_nxt    = 1'b0;
        case (state)
            IDLE: begin
                dis_nxt = 1'b1;
                if (en && found) begin
                    state_nxt = GRANT;
                    gidx_nxt  = pick;
                    cnt_nxt   = 8'd1;
                    dis_nxt   = 1'b0;
                    gn_nxt    = 1'b1;
                end
            end
            GRANT: begin
                if (term) begin
                    state_nxt = IDLE;
                    dis_nxt   = 1'b1;
                    ptr_nxt   = gidx + 3'd1;
                end else if (cnt != 8'hFF) begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                dis_nxt   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= 3'd0;
            gidx      <= 3'd0;
            cnt       <= 8'd0;
            dis       <= 1'b1;
            grant_new <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            gidx      <= gidx_nxt;
            cnt       <= cnt_nxt;
            dis       <= dis_nxt;
            grant_new <= gn_nxt;
        end
    end

    // gidx is a register, so the select lines are registered and hold their value while disabled.
    assign {sel2, sel1, sel0} = gidx;

endmodule
